// File: rtl/lcm_seq_if.sv
// rtl/lcm_seq_if.sv - operand/result handshake bundle for the lcm_seq stage
interface lcm_seq_if #(
  parameter int WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [WIDTH-1:0]       g;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     lcm;
  logic                   err;

  modport slave (
    input  in_valid, a, b, g, out_ready,
    output in_ready, out_valid, lcm, err
  );

  modport master (
    output in_valid, a, b, g, out_ready,
    input  in_ready, out_valid, lcm, err
  );
endinterface

// File: rtl/lcm_seq.sv
// rtl/lcm_seq.sv - sequential lcm = (a / g) * b via restoring divide then shift-add multiply
module lcm_seq #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  lcm_seq_if.slave    bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     a_q, b_q, g_q;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   lcm_q;
  logic                 err_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic [CW-1:0]        div_idx;
  logic [WIDTH:0]       rem_shift;
  logic                 fault;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.lcm       = lcm_q;
  assign bus.err       = err_q;

  // Division walks a from MSB down; the multiply walks b from LSB up.
  always_comb begin
    div_idx   = LAST - cnt_q;
    rem_shift = {rem_q[WIDTH-1:0], a_q[div_idx]};
    rem_d     = rem_shift;
    q_d       = q_q;
    if (rem_shift >= {1'b0, g_q}) begin
      rem_d        = rem_shift - {1'b0, g_q};
      q_d[div_idx] = 1'b1;
    end
    acc_d = acc_q;
    if (b_q[cnt_q]) begin
      acc_d = acc_q + ({{WIDTH{1'b0}}, q_q} << cnt_q);
    end
    fault = (g_q == '0) | (rem_q != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      g_q         <= '0;
      q_q         <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      lcm_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            g_q        <= bus.g;
            q_q        <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= DIV;
          end
        end
        DIV: begin
          q_q   <= q_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= MUL;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            err_q       <= fault;
            lcm_q       <= fault ? '0 : acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcm_seq.sv
// tb/tb_lcm_seq.sv - directed self-checking bench for lcm_seq
module tb_lcm_seq;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n;

  lcm_seq_if #(.WIDTH(8)) bus ();

  lcm_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] gv);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    chk("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
    bus.a        = av;
    bus.b        = bv;
    bus.g        = gv;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("in_ready_after_accept", {31'd0, bus.in_ready}, 32'd0);
  endtask

  // Counts edges from the accepting edge until out_valid, then checks the result.
  task automatic wait_result(input string tag, input logic [15:0] exp_lcm, input logic exp_err);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd16);
    chk({tag, "_lcm"}, {16'd0, bus.lcm}, {16'd0, exp_lcm});
    chk({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_in_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.g = '0;
    #22;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_lcm", {16'd0, bus.lcm}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    rst = 1'b0;
    tick();

    send(8'd48, 8'd18, 8'd6);
    wait_result("basic", 16'd144, 1'b0);
    drain("basic");

    // Back-to-back: second operands presented while the first is in flight.
    bus.out_ready = 1'b1;
    send(8'd17, 8'd13, 8'd1);
    bus.a = 8'd255;
    bus.b = 8'd254;
    bus.g = 8'd1;
    bus.in_valid = 1'b1;
    wait_result("b2b_first", 16'd221, 1'b0);
    tick();
    chk("b2b_idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("b2b_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_second_accept", {31'd0, bus.in_ready}, 32'd0);
    wait_result("b2b_second", 16'd64770, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    chk("b2b_done_in_ready", {31'd0, bus.in_ready}, 32'd1);

    send(8'd0, 8'd5, 8'd5);
    wait_result("a_zero", 16'd0, 1'b0);
    drain("a_zero");

    send(8'd0, 8'd0, 8'd0);
    wait_result("all_zero", 16'd0, 1'b1);
    drain("all_zero");

    send(8'd48, 8'd18, 8'd5);
    wait_result("bad_g", 16'd0, 1'b1);
    drain("bad_g");

    // Stall in DONE with stray input pulses.
    send(8'd24, 8'd36, 8'd12);
    wait_result("stall", 16'd72, 1'b0);
    bus.a = 8'd1;
    bus.b = 8'd1;
    bus.g = 8'd1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      tick();
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_lcm", {16'd0, bus.lcm}, 32'd72);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    drain("stall");

    // Asynchronous reset during the fourth division step.
    send(8'd100, 8'd25, 8'd25);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_lcm", {16'd0, bus.lcm}, 32'd0);
    chk("mid_rst_err", {31'd0, bus.err}, 32'd0);
    #4;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bus.out_valid === 1'b1) n++;
    end
    chk("mid_rst_no_result", n, 32'd0);

    send(8'd81, 8'd27, 8'd27);
    wait_result("after_rst", 16'd81, 1'b0);
    drain("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcm_seq.md
Name: lcm_seq

Overview:
- Sequential LCM stage downstream of the combinational gcd block.
- Consumes operands a, b and their GCD g, and computes lcm = (a / g) * b.
- Uses a WIDTH-cycle restoring divider followed by a WIDTH-cycle shift-add multiplier.
- Valid/ready handshakes on both sides, so it can sit between the gcd block and a result sink.

Parameters:
- WIDTH, 8, operand width of a, b, g; result width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a, b, g are valid this cycle.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand a.
- b  input  WIDTH  operand b.
- g  input  WIDTH  gcd(a,b) from the upstream gcd block.
- out_valid  output  1  lcm/err valid (high only in DONE).
- out_ready  input  1  downstream accepts the result.
- lcm  output  2*WIDTH  least common multiple.
- err  output  1  g==0 or g does not divide a.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, in_ready=1, out_valid=0, lcm=0, err=0, all internal registers cleared. A result in progress is discarded; no out_valid pulse follows.
- States:
  - IDLE: in_ready=1. If in_valid is high on a clock edge, latch a, b, g, clear the quotient, remainder and accumulator, set the step counter to 0, go to DIV.
  - DIV: one restoring-division step per cycle, MSB first: rem = {rem, a[bit]}; if rem >= g then rem -= g and q[bit]=1. After WIDTH steps go to MUL. If g==0, the steps still run (rem >= 0 is always true, so q becomes all ones); err handling below overrides the result.
  - MUL: one shift-add step per cycle over the bits of b, LSB first: if b[bit] then acc += q << bit. After WIDTH steps go to DONE. Register lcm from acc, and err = (g==0) | (rem!=0). If err=1, lcm is forced to 0.
  - DONE: out_valid=1; lcm and err held stable. If out_ready is high on a clock edge, go to IDLE. out_valid=0 and in_ready=1 from the next cycle.
- Latency:
  - Fixed, independent of operand values: out_valid rises exactly 2*WIDTH rising edges after the accepting edge (16 for WIDTH=8).
  - Throughput is one result per 2*WIDTH+2 cycles minimum; with out_ready held high, in_ready returns 2*WIDTH+1 edges after acceptance.
- Handshakes:
  - Input: transfer occurs when in_valid & in_ready at a rising edge. in_valid is ignored outside IDLE; operands are not sampled again until IDLE.
  - Output: transfer occurs when out_valid & out_ready. Holding out_ready low stalls in DONE indefinitely with outputs stable.
  - out_ready is ignored outside DONE.
- Arithmetic:
  - The quotient is WIDTH bits and the accumulator 2*WIDTH bits; no overflow is possible: (a/g)*b <= (2^WIDTH-1)^2.
  - The remainder register is WIDTH+1 bits so the compare does not overflow.
- Zero cases:
  - a==0 with g==b!=0: q=0, lcm=0, err=0.
  - b==0 with g==a!=0: lcm=0, err=0.
  - a==b==g==0: err=1, lcm=0.
- Simultaneous events: a reset asserted in the same cycle as an in_valid or out_ready handshake wins; the handshake does not occur.

Test Plan:
- Reset, then a=48 b=18 g=6, in_valid for 1 cycle -> in_ready drops next cycle; out_valid after exactly 16 edges; lcm=144, err=0.
- a=17 b=13 g=1, then a=255 b=254 g=1 back-to-back with out_ready=1 -> lcm=221, then lcm=64770 (max range), err=0 both; second input accepted only once in_ready is high again.
- a=0 b=5 g=5 -> lcm=0, err=0. Then a=0 b=0 g=0 -> lcm=0, err=1. Both with the same 16-cycle latency.
- a=48 b=18 g=5 (inconsistent g) -> rem=3 so err=1, lcm=0.
- a=24 b=36 g=12 with out_ready held low 10 cycles after out_valid -> lcm=72 held stable with out_valid=1 throughout; in_valid pulses during the stall ignored; after out_ready=1 for one edge, out_valid=0 and in_ready=1.
- a=100 b=25 g=25: assert rst asynchronously (between edges) during DIV step 4 -> outputs go to reset values immediately; no out_valid. A fresh request a=81 b=27 g=27 -> lcm=81, err=0.
